// File: rtl/dino_pkg.sv
// Shared encodings for the dino game blocks: game-state codes and the vertical-motion state enum.
package dino_pkg;

    localparam logic [1:0] GS_IDLE = 2'b00;
    localparam logic [1:0] GS_DEAD = 2'b01;
    localparam logic [1:0] GS_RUN  = 2'b10;

    typedef enum logic [1:0] {
        GROUND = 2'd0,
        RISE   = 2'd1,
        FALL   = 2'd2
    } dino_state_e;

    function automatic logic is_airborne(dino_state_e s);
        return s != GROUND;
    endfunction

endpackage

// File: rtl/dino_jump_ctrl_if.sv
// Bundle between the game controller (master) and the dino vertical-motion block (slave).
interface dino_jump_ctrl_if #(
    parameter int YW = 11,
    parameter int VW = 7
);
    logic [1:0]           gameState;
    logic                 jump;
    logic                 duck;
    logic [YW-1:0]        GroundY;
    logic [YW-1:0]        DinoY;
    logic signed [VW-1:0] V;
    logic                 Airborne;
    logic                 onGround;
    logic                 landed;

    modport master (
        output gameState, jump, duck, GroundY,
        input  DinoY, V, Airborne, onGround, landed
    );

    modport slave (
        input  gameState, jump, duck, GroundY,
        output DinoY, V, Airborne, onGround, landed
    );
endinterface

// File: rtl/dino_integrator.sv
// One physics step: next Y from the old V, next V with gravity saturated at +V_MAX,
// plus the ground and ceiling compares. Purely combinational.
module dino_integrator #(
    parameter int YW    = 11,
    parameter int VW    = 7,
    parameter int V_MAX = 24,
    parameter int MIN_Y = 0
) (
    input  logic [YW-1:0]        y_i,
    input  logic signed [VW-1:0] v_i,
    input  logic [VW-1:0]        g_i,
    input  logic [YW-1:0]        ground_i,
    output logic [YW-1:0]        y_o,
    output logic signed [VW-1:0] v_o,
    output logic                 ground_hit_o,
    output logic                 ceil_hit_o
);
    localparam int SW = YW + 1;
    localparam logic signed [VW:0] VMAX_S = (VW+1)'(V_MAX);

    logic signed [SW-1:0] y_sum;
    logic signed [VW:0]   v_sum;

    always_comb begin
        // Zero-extend Y and the ground line so neither compare can wrap.
        y_sum        = $signed({1'b0, y_i}) + $signed({{(SW-VW){v_i[VW-1]}}, v_i});
        v_sum        = $signed({v_i[VW-1], v_i}) + $signed({1'b0, g_i});
        ground_hit_o = y_sum >= $signed({1'b0, ground_i});
        ceil_hit_o   = y_sum <  $signed(SW'(MIN_Y));

        y_o = y_sum[YW-1:0];
        if (ground_hit_o)
            y_o = ground_i;
        else if (ceil_hit_o)
            y_o = YW'(MIN_Y);

        v_o = v_sum[VW-1:0];
        if (v_sum > VMAX_S)
            v_o = VW'(V_MAX);
    end
endmodule

// File: rtl/dino_jump_ctrl.sv
// Per-frame vertical-motion controller for the player dino (GROUND/RISE/FALL).
// Optional feature macro: DINO_FAST_FALL_EN (duck in FALL doubles gravity).
module dino_jump_ctrl
    import dino_pkg::*;
#(
    parameter int YW       = 11,
    parameter int VW       = 7,
    parameter int V_INIT   = 24,
    parameter int G        = 2,
    parameter int G_HOLD   = 1,
    parameter int MAX_HOLD = 8,
    parameter int V_MAX    = 24,
    parameter int MIN_Y    = 0
) (
    input logic             FrameClk,
    input logic             rst,
    dino_jump_ctrl_if.slave bus
);
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam int SW = YW + 1;

    dino_state_e          state_q, state_d;
    logic [YW-1:0]        y_q, y_d;
    logic signed [VW-1:0] v_q, v_d;
    logic [HW-1:0]        hold_q, hold_d;
    logic                 landed_q, landed_d;

    logic [VW-1:0]        grav;
    logic [YW-1:0]        ny;
    logic signed [VW-1:0] nv;
    logic                 hit_gnd, hit_ceil;
    logic signed [SW-1:0] launch_y;

    always_comb begin
        grav = VW'(G);
        if (state_q == RISE && bus.jump && hold_q < HW'(MAX_HOLD))
            grav = VW'(G_HOLD);
`ifdef DINO_FAST_FALL_EN
        else if (state_q == FALL && bus.duck)
            grav = VW'(2 * G);
`endif
    end

`ifndef DINO_FAST_FALL_EN
    logic unused_duck;
    assign unused_duck = bus.duck;
`endif

    dino_integrator #(
        .YW(YW), .VW(VW), .V_MAX(V_MAX), .MIN_Y(MIN_Y)
    ) u_integ (
        .y_i(y_q), .v_i(v_q), .g_i(grav), .ground_i(bus.GroundY),
        .y_o(ny), .v_o(nv), .ground_hit_o(hit_gnd), .ceil_hit_o(hit_ceil)
    );

    always_ff @(posedge FrameClk) begin
        if (rst) begin
            state_q  <= GROUND;
            y_q      <= bus.GroundY;
            v_q      <= '0;
            hold_q   <= '0;
            landed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            y_q      <= y_d;
            v_q      <= v_d;
            hold_q   <= hold_d;
            landed_q <= landed_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        y_d      = y_q;
        v_d      = v_q;
        hold_d   = hold_q;
        landed_d = 1'b0;
        launch_y = $signed({1'b0, bus.GroundY}) - $signed(SW'(V_INIT));
        unique case (bus.gameState)
            GS_RUN: begin
                if (state_q == GROUND) begin
                    y_d    = bus.GroundY;
                    v_d    = '0;
                    hold_d = '0;
                    if (bus.jump) begin
                        state_d = RISE;
                        v_d     = VW'(G - V_INIT);
                        y_d     = (launch_y < $signed(SW'(MIN_Y))) ? YW'(MIN_Y)
                                                                   : launch_y[YW-1:0];
                    end
                end else begin
                    y_d = ny;
                    v_d = nv;
                    if (state_q == RISE) begin
                        if (hold_q < HW'(MAX_HOLD))
                            hold_d = hold_q + HW'(1);
                        if (!nv[VW-1])
                            state_d = FALL;
                    end
                    // Landing outranks the ceiling if a tiny GroundY makes both true.
                    if (hit_gnd) begin
                        state_d  = GROUND;
                        v_d      = '0;
                        landed_d = 1'b1;
                    end else if (hit_ceil) begin
                        state_d = FALL;
                        v_d     = '0;
                    end
                end
            end
            GS_DEAD: begin
            end
            default: begin
                state_d = GROUND;
                y_d     = bus.GroundY;
                v_d     = '0;
                hold_d  = '0;
            end
        endcase
    end

    always_comb begin
        bus.Airborne = is_airborne(state_q);
        bus.onGround = ~is_airborne(state_q);
    end

    assign bus.DinoY  = y_q;
    assign bus.V      = v_q;
    assign bus.landed = landed_q;
endmodule
